// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch (if_*) and load/store (dm_*) requesters.
// Latency: 2 cycles minimum (req edge -> mem_req -> ack), one idle bubble between accesses; callers hold req until ack.
// Optional ARB_TIMEOUT_EN: abandon an access after TIMEOUT busy cycles without mem_ready and flag err.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          err
);

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("mem_port_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

    state_t        state, nxt_state;
    logic          last_dm, nxt_last_dm;
    logic          nxt_mem_req, nxt_mem_we, nxt_busy;
    logic [AW-1:0] nxt_mem_addr;
    logic [DW-1:0] nxt_mem_wdata, nxt_if_rdata, nxt_dm_rdata;
    logic          nxt_if_ack, nxt_dm_ack;
    logic          if_q, dm_q, grant_dm;

    // A side whose ack is showing this cycle is still holding req from the finished access.
    assign if_q     = if_req & ~if_ack;
    assign dm_q     = dm_req & ~dm_ack;
    assign grant_dm = dm_q & (~if_q | ~last_dm);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    logic [CW-1:0] cnt, nxt_cnt;
    logic          nxt_err;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        nxt_state     = state;
        nxt_last_dm   = last_dm;
        nxt_mem_req   = mem_req;
        nxt_mem_we    = mem_we;
        nxt_mem_addr  = mem_addr;
        nxt_mem_wdata = mem_wdata;
        nxt_busy      = busy;
        nxt_if_rdata  = if_rdata;
        nxt_dm_rdata  = dm_rdata;
        nxt_if_ack    = 1'b0;
        nxt_dm_ack    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        nxt_cnt       = cnt;
        nxt_err       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (if_q | dm_q) begin
                    nxt_mem_req = 1'b1;
                    nxt_busy    = 1'b1;
                    nxt_last_dm = grant_dm;
`ifdef ARB_TIMEOUT_EN
                    nxt_cnt     = '0;
`endif
                    if (grant_dm) begin
                        nxt_state     = DM_BUSY;
                        nxt_mem_we    = dm_we;
                        nxt_mem_addr  = dm_addr;
                        nxt_mem_wdata = dm_wdata;
                    end else begin
                        nxt_state     = IF_BUSY;
                        nxt_mem_we    = 1'b0;
                        nxt_mem_addr  = if_addr;
                    end
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (mem_ready) begin
                    nxt_state   = IDLE;
                    nxt_mem_req = 1'b0;
                    nxt_mem_we  = 1'b0;
                    nxt_busy    = 1'b0;
                    if (state == IF_BUSY) begin
                        nxt_if_rdata = mem_rdata;
                        nxt_if_ack   = 1'b1;
                    end else begin
                        nxt_dm_rdata = mem_rdata;
                        nxt_dm_ack   = 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    nxt_state   = IDLE;
                    nxt_mem_req = 1'b0;
                    nxt_mem_we  = 1'b0;
                    nxt_busy    = 1'b0;
                    nxt_err     = 1'b1;
                    if (state == IF_BUSY) begin
                        nxt_if_rdata = '0;
                        nxt_if_ack   = 1'b1;
                    end else begin
                        nxt_dm_rdata = '0;
                        nxt_dm_ack   = 1'b1;
                    end
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
`endif
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            last_dm   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state     <= nxt_state;
            last_dm   <= nxt_last_dm;
            mem_req   <= nxt_mem_req;
            mem_we    <= nxt_mem_we;
            mem_addr  <= nxt_mem_addr;
            mem_wdata <= nxt_mem_wdata;
            busy      <= nxt_busy;
            if_ack    <= nxt_if_ack;
            dm_ack    <= nxt_dm_ack;
            if_rdata  <= nxt_if_rdata;
            dm_rdata  <= nxt_dm_rdata;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= nxt_cnt;
            err <= nxt_err;
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-port memory between the instruction-fetch requester (if_*) and the load/store requester (dm_*) of the processor core.
- Sits between the core's fetch/data paths and the shared memory.
- Sequences each access as a request/grant/ack transaction and alternates service when both sides compete.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits
TIMEOUT, 15, maximum cycles to wait for mem_ready (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous active-low reset (0 at posedge = reset)
if_req  input  1  fetch request, held until if_ack
if_addr  input  AW  fetch address
if_ack  output  1  one-cycle pulse: fetch done, if_rdata valid
if_rdata  output  DW  fetched word
dm_req  input  1  data request, held until dm_ack
dm_we  input  1  1 = store, 0 = load
dm_addr  input  AW  data address
dm_wdata  input  DW  store data
dm_ack  output  1  one-cycle pulse: data access done, dm_rdata valid for loads
dm_rdata  output  DW  loaded word
mem_req  output  1  memory access active
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data
mem_ready  input  1  memory completes the access on this edge
busy  output  1  1 while a memory transaction is in progress
err  output  1  one-cycle timeout pulse (ARB_TIMEOUT_EN only)

Behaviour:
- Reset (reset=0 at posedge):
  - state=IDLE, last_grant=IF.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata, busy, err.
- All outputs are registered.
- States: IDLE, IF_BUSY, DM_BUSY.
- IDLE arbitration:
  - Requests are qualified: if_req&~if_ack and dm_req&~dm_ack. A request whose ack is high this cycle is ignored.
  - Only one qualified request: grant it.
  - Both qualified: grant the side opposite last_grant. After reset last_grant=IF, so DM wins the first tie.
  - On grant, latch address (plus we/wdata for DM) into mem_* and set mem_req=1, busy=1 from the next cycle. Enter IF_BUSY or DM_BUSY and update last_grant.
- BUSY states:
  - mem_req, mem_addr, mem_we and mem_wdata are held constant.
  - IF_BUSY always drives mem_we=0.
  - Requester inputs are ignored, including changes to address and data.
- Completion:
  - Trigger: mem_ready=1 sampled at a posedge in a BUSY state.
  - At that edge: capture mem_rdata into if_rdata or dm_rdata, pulse the matching ack for exactly the next cycle, clear mem_req, mem_we and busy, return to IDLE.
  - Stores also update dm_rdata with mem_rdata; the core ignores it.
- Latency: request sampled at edge N, so mem_req=1 in cycle N+1. With mem_ready already high at edge N+1, ack=1 in cycle N+2. Minimum 2 cycles per access and 1 idle bubble between back-to-back accesses.
- mem_ready while in IDLE: ignored.
- Requester dropping req mid-transaction: the transaction still completes and the ack still pulses.
- if_rdata and dm_rdata hold their values until the next completion on the same side.
- Reset during BUSY: the transaction is abandoned, mem_req=0 next cycle, no ack issued.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 4-bit+ cycle counter clears on entry to BUSY and increments each BUSY cycle.
  - If TIMEOUT cycles elapse without mem_ready: return to IDLE and clear mem_req and busy.
  - Pulse the matching ack and err together for one cycle; the matching rdata is set to 0.
  - mem_ready on the same edge as the expiry counts as normal completion, with no err.
- Not defined: BUSY waits indefinitely for mem_ready; err is tied 0; no counter logic exists.

Test Plan:
- Reset: hold reset=0 for 2 cycles with if_req=1 -> all outputs 0 and no mem_req; after release, mem_req=1 one cycle later with mem_addr=if_addr.
- Fetch: if_addr=0x00000010, mem_ready=1 immediately, mem_rdata=0xDEADBEEF -> mem_req high 1 cycle, if_ack pulses 1 cycle with if_rdata=0xDEADBEEF.
- Store with wait states: dm_we=1, dm_addr=0x100, dm_wdata=0x12345678, mem_ready delayed 3 cycles -> mem_we=1 and address/data stable for 3 cycles, then a single dm_ack.
- Contention: if_req and dm_req both held high for 4 transactions -> grant order DM, IF, DM, IF; no ack wider than 1 cycle.
- Reset mid-access: assert reset=0 in DM_BUSY -> mem_req=0 next cycle, no dm_ack; the next request is served normally.
- ARB_TIMEOUT_EN, TIMEOUT=15, mem_ready never asserted on a fetch -> after 15 BUSY cycles err=1 and if_ack=1 for one cycle with if_rdata=0, then IDLE.
